// File: rtl/mem_access_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the DataMemory port.
// The controller sits on the slave modport; the pipeline and DataMemory
// together form the master side.
interface mem_access_ctrl_if;

   // Request from the EXE/MEM pipeline register
   logic        mem_r_en;
   logic        mem_w_en;
   logic [31:0] alu_addr;
   logic [31:0] st_val;

   // Response towards the pipeline and the MEM/WB register
   logic        freeze;
   logic        ready;
   logic        addr_err;
   logic [31:0] rd_data;

   // DataMemory port
   logic        dm_readSig;
   logic        dm_writeSig;
   logic [31:0] dm_address;
   logic [31:0] dm_dataIn;
   logic [31:0] dm_dataOut;

   modport master (
      output mem_r_en, mem_w_en, alu_addr, st_val, dm_dataOut,
      input  freeze, ready, addr_err, rd_data,
      input  dm_readSig, dm_writeSig, dm_address, dm_dataIn
   );

   modport slave (
      input  mem_r_en, mem_w_en, alu_addr, st_val, dm_dataOut,
      output freeze, ready, addr_err, rd_data,
      output dm_readSig, dm_writeSig, dm_address, dm_dataIn
   );

endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller in front of DataMemory.
// Accepts a load/store request, converts the byte address into a word index,
// holds the DataMemory strobes for WAIT_CYCLES cycles while stalling the
// pipeline, then reports completion with a one-cycle ready pulse.
// Illegal (misaligned or out-of-window) accesses skip DataMemory entirely and
// complete one cycle after they are seen, with addr_err set.
// WAIT_CYCLES must lie in 1..15 so the wait counter fits in four bits.
module mem_access_ctrl #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned MEM_WORDS   = 64,
   parameter int unsigned WAIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   mem_access_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // First byte address of the window and one past its last byte; the end is
   // kept at 33 bits so a window touching the top of the address space still
   // compares correctly.
   localparam logic [31:0] BASE_LO  = 32'(BASE_ADDR);
   localparam logic [32:0] ADDR_END = 33'(BASE_ADDR) + 33'(4 * MEM_WORDS);
   localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);

   state_t      state_q,    state_d;
   logic [3:0]  cnt_q,      cnt_d;
   logic        is_write_q, is_write_d;
   logic [31:0] addr_q,     addr_d;
   logic [31:0] data_q,     data_d;
   logic        err_q,      err_d;
   logic [31:0] rd_data_q,  rd_data_d;

   logic        req;
   logic        req_err;

   // Decode the incoming request and classify its address as legal or not.
   always_comb begin
      req     = bus.mem_r_en | bus.mem_w_en;
      req_err = (bus.alu_addr[1:0] != 2'b00)
              | (bus.alu_addr < BASE_LO)
              | ({1'b0, bus.alu_addr} >= ADDR_END);
   end

   // Next-state logic: latch a request in IDLE, count out the wait in BUSY,
   // and always fall back to IDLE after the single DONE cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = err_q;
      rd_data_d  = rd_data_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               is_write_d = bus.mem_w_en;
               addr_d     = bus.alu_addr;
               data_d     = bus.st_val;
               err_d      = req_err;
               cnt_d      = 4'd0;
               if (req_err) begin
                  state_d = DONE;
                  if (!bus.mem_w_en) begin
                     rd_data_d = 32'd0;
                  end
               end else begin
                  state_d = BUSY;
               end
            end
         end

         BUSY: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = 4'd0;
               state_d = DONE;
               if (!is_write_q) begin
                  rd_data_d = bus.dm_dataOut;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Output decode: stall while a request is pending or in flight, drive the
   // DataMemory strobes only in BUSY, and pulse ready only in DONE.
   always_comb begin
      bus.freeze      = 1'b0;
      bus.ready       = 1'b0;
      bus.addr_err    = 1'b0;
      bus.dm_readSig  = 1'b0;
      bus.dm_writeSig = 1'b0;
      bus.dm_address  = 32'd0;
      bus.dm_dataIn   = 32'd0;

      case (state_q)
         IDLE: begin
            bus.freeze = req;
         end

         BUSY: begin
            bus.freeze      = 1'b1;
            bus.dm_readSig  = ~is_write_q;
            bus.dm_writeSig = is_write_q;
            bus.dm_address  = (addr_q - BASE_LO) >> 2;
            bus.dm_dataIn   = data_q;
         end

         DONE: begin
            bus.ready    = 1'b1;
            bus.addr_err = err_q;
         end

         default: begin
            bus.freeze = 1'b0;
         end
      endcase
   end

   assign bus.rd_data = rd_data_q;

   // State and latched-request registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         is_write_q <= 1'b0;
         addr_q     <= 32'd0;
         data_q     <= 32'd0;
         err_q      <= 1'b0;
         rd_data_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         err_q      <= err_d;
         rd_data_q  <= rd_data_d;
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: a small DataMemory model on the bus, a
// transaction-level reference (word array plus expected load register), and
// directed plus randomized load/store traffic.
module tb_mem_access_ctrl;

   localparam int unsigned BASE  = 1024;
   localparam int unsigned WORDS = 64;
   localparam int unsigned WAITC = 4;

   logic clk;
   logic rst;

   int checkCount;
   int passCount;

   logic [31:0] dmem   [WORDS];
   logic [31:0] refMem [WORDS];
   logic [31:0] expRd;

   mem_access_ctrl_if bus ();

   mem_access_ctrl #(
      .BASE_ADDR   (BASE),
      .MEM_WORDS   (WORDS),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 ns period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] initWord(input int i);
      return 32'h9E37_79B9 * 32'(i + 1);
   endfunction

   // DataMemory stand-in: combinational read, write on the clock edge,
   // contents restored to a known pattern while reset is held
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < WORDS; i++) dmem[i] <= initWord(i);
      end else if (bus.dm_writeSig) begin
         dmem[bus.dm_address[5:0]] <= bus.dm_dataIn;
      end
   end
   assign bus.dm_dataOut = dmem[bus.dm_address[5:0]];

   // Single comparison point for every check in the bench
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
   endtask

   task automatic resetModel();
      for (int i = 0; i < WORDS; i++) refMem[i] = initWord(i);
      expRd = 32'd0;
   endtask

   // Quiet cycles with no request: nothing may move and rd_data must hold
   task automatic idleCycles(input int n);
      for (int k = 0; k < n; k++) begin
         bus.mem_r_en = 1'b0;
         bus.mem_w_en = 1'b0;
         bus.alu_addr = $urandom;
         bus.st_val   = $urandom;
         @(negedge clk);
         checkOutput("idle_freeze",  bus.freeze,      0);
         checkOutput("idle_ready",   bus.ready,       0);
         checkOutput("idle_err",     bus.addr_err,    0);
         checkOutput("idle_rd",      bus.dm_readSig,  0);
         checkOutput("idle_wr",      bus.dm_writeSig, 0);
         checkOutput("idle_addr",    bus.dm_address,  0);
         checkOutput("idle_din",     bus.dm_dataIn,   0);
         checkOutput("idle_rd_data", bus.rd_data,     expRd);
         @(posedge clk);
         #1;
      end
   endtask

   // One complete access, entered and left just after a rising edge.
   // Expected timing: stall from the request cycle through the wait, ready
   // WAITC+1 cycles later for a legal access, or one cycle later if illegal.
   task automatic applyStimulus(input logic rEn, input logic wEn,
                                input logic [31:0] addr, input logic [31:0] data);
      logic        err;
      logic [31:0] idx;
      err = (addr % 4 != 0) || (addr < BASE) || (64'(addr) >= 64'(BASE + 4 * WORDS));
      idx = (addr - BASE) / 4;

      bus.mem_r_en = rEn;
      bus.mem_w_en = wEn;
      bus.alu_addr = addr;
      bus.st_val   = data;
      @(negedge clk);
      checkOutput("req_freeze",  bus.freeze,      1);
      checkOutput("req_ready",   bus.ready,       0);
      checkOutput("req_rd",      bus.dm_readSig,  0);
      checkOutput("req_wr",      bus.dm_writeSig, 0);
      checkOutput("req_addr",    bus.dm_address,  0);
      checkOutput("req_rd_data", bus.rd_data,     expRd);

      if (!err) begin
         for (int k = 1; k <= WAITC; k++) begin
            @(posedge clk);
            #1;
            bus.mem_r_en = 1'($urandom);
            bus.mem_w_en = 1'($urandom);
            bus.alu_addr = $urandom;
            bus.st_val   = $urandom;
            @(negedge clk);
            checkOutput("busy_freeze",  bus.freeze,      1);
            checkOutput("busy_ready",   bus.ready,       0);
            checkOutput("busy_err",     bus.addr_err,    0);
            checkOutput("busy_rd",      bus.dm_readSig,  !wEn);
            checkOutput("busy_wr",      bus.dm_writeSig, wEn);
            checkOutput("busy_addr",    bus.dm_address,  idx);
            checkOutput("busy_din",     bus.dm_dataIn,   data);
            checkOutput("busy_rd_data", bus.rd_data,     expRd);
         end
         if (wEn) refMem[idx[5:0]] = data;
         else     expRd = refMem[idx[5:0]];
      end else if (!wEn) begin
         expRd = 32'd0;
      end

      // Completion cycle: the pipeline still presents the finished request
      @(posedge clk);
      #1;
      bus.mem_r_en = rEn;
      bus.mem_w_en = wEn;
      bus.alu_addr = addr;
      bus.st_val   = data;
      @(negedge clk);
      checkOutput("done_ready",   bus.ready,       1);
      checkOutput("done_err",     bus.addr_err,    err);
      checkOutput("done_freeze",  bus.freeze,      0);
      checkOutput("done_rd",      bus.dm_readSig,  0);
      checkOutput("done_wr",      bus.dm_writeSig, 0);
      checkOutput("done_addr",    bus.dm_address,  0);
      checkOutput("done_din",     bus.dm_dataIn,   0);
      checkOutput("done_rd_data", bus.rd_data,     expRd);
      @(posedge clk);
      #1;
   endtask

   // Watchdog so the run always ends even if the clock stops advancing work
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        rEn, wEn;
      logic [31:0] addr;
      int          kind;

      checkCount   = 0;
      passCount    = 0;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      bus.alu_addr = 32'd0;
      bus.st_val   = 32'd0;
      resetModel();

      // Reset held for 28 ns with no requests
      rst = 1'b1;
      #20;
      checkOutput("rst_freeze", bus.freeze,      0);
      checkOutput("rst_ready",  bus.ready,       0);
      checkOutput("rst_err",    bus.addr_err,    0);
      checkOutput("rst_rdata",  bus.rd_data,     0);
      checkOutput("rst_wr",     bus.dm_writeSig, 0);
      checkOutput("rst_rd",     bus.dm_readSig,  0);
      #8;
      rst = 1'b0;
      @(posedge clk);
      #1;
      idleCycles(3);

      $display("[TB] directed accesses");
      applyStimulus(1'b0, 1'b1, 32'd1024, 32'h5555_5555);
      applyStimulus(1'b0, 1'b1, 32'd1048, 32'hAAAA_AAAA);
      idleCycles(1);
      applyStimulus(1'b1, 1'b0, 32'd1048, 32'h0);
      idleCycles(2);
      applyStimulus(1'b1, 1'b0, 32'd1061, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'd1280, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'd1048, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'd1028, 32'hFFFF_0000);
      idleCycles(1);
      applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
      idleCycles(1);

      $display("[TB] reset during a store");
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b1;
      bus.alu_addr = 32'd1040;
      bus.st_val   = 32'h1234_5678;
      @(negedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("abort_wr_before", bus.dm_writeSig, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      #2;
      bus.mem_w_en = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("abort_wr_async", bus.dm_writeSig, 0);
      checkOutput("abort_freeze",   bus.freeze,      0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      resetModel();
      idleCycles(WAITC + 3);

      $display("[TB] randomized accesses");
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         wEn  = 1'($urandom);
         rEn  = wEn ? 1'($urandom) : 1'b1;
         case (kind)
            0:       addr = BASE + 4 * $urandom_range(0, WORDS - 1) + $urandom_range(1, 3);
            1:       addr = 32'($urandom_range(0, BASE - 1)) & ~32'd3;
            2:       addr = BASE + 4 * WORDS + 4 * $urandom_range(0, 100000);
            default: addr = BASE + 4 * $urandom_range(0, WORDS - 1);
         endcase
         applyStimulus(rEn, wEn, addr, $urandom);
         idleCycles($urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
